program_counter_ras: RTL
========================

# program_counter_ras

Parametrised successor to the team's single-mode program counter: generates the fetch address each instruction slot and adds relative branches plus a hardware return-address stack (RAS) for call/return. Sits at the head of the fetch stage; decode drives `op`/`target`, the fetch unit consumes `pc`. All state is registered; `pc` is the sole address source for instruction memory.

## Interface

Parameters:
- PC_WIDTH, 32, width of `pc`, `target`, and every RAS entry
- INSTR_BYTES, 8, sequential increment in bytes
- RAS_DEPTH, 8, number of RAS entries (≥2)
- RESET_VECTOR, 0, `pc` value while in reset

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous assert, active-low (`rst`=0 resets)
- latch  in  1  advance enable; 0 = hold all state
- op  in  3  operation select, sampled only when `latch`=1
- target  in  PC_WIDTH  absolute address (JUMP/CALL) or two's-complement byte offset (BRANCH_REL)
- pc  out  PC_WIDTH  current fetch address
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_full  out  1  `ras_count`==RAS_DEPTH
- ras_empty  out  1  `ras_count`==0
- ras_overflow  out  1  sticky: CALL issued while full
- ras_underflow  out  1  sticky: RET issued while empty

## Operation

- Reset (`rst`=0, asynchronous): `pc`=RESET_VECTOR, `ras_count`=0, `ras_empty`=1, `ras_full`=0, both sticky flags 0. RAS entry contents are don't-care.
- `latch`=0: `pc`, RAS, count and flags hold; `op`/`target` ignored.
- `latch`=1, by `op`:
  - 0 NEXT: `pc` ← `pc`+INSTR_BYTES
  - 1 JUMP: `pc` ← `target`
  - 2 BRANCH_REL: `pc` ← `pc`+`target` (offset is signed; the add is plain PC_WIDTH modular addition)
  - 3 CALL: push `pc`+INSTR_BYTES; `pc` ← `target`. If full: push discarded, stack unchanged, `ras_overflow` ← 1, jump still taken.
  - 4 RET: `pc` ← top entry; pop. If empty: `pc` ← `pc`+INSTR_BYTES, `ras_underflow` ← 1.
  - 5–7 reserved: behave as NEXT.
- All address arithmetic wraps modulo 2^PC_WIDTH; no carry out, no alignment check; `target` used verbatim.
- Sticky flags are cleared only by reset.
- Stack is a strict LIFO; the top is the most recent unpopped push. No simultaneous push and pop exists (one op per cycle).

## Timing

- Single-cycle: op applied at edge N → new `pc`, `ras_count`, flags visible after edge N; combinational path only from state to outputs (all outputs registered or decoded from registered count).
- RET reads the top entry in the same cycle it pops; a CALL at edge N followed by RET at edge N+1 returns the address pushed at edge N (no bypass hazard).
- Reset asserted mid-operation: outputs go to reset values immediately, independent of `clk`; on deassertion the first active edge applies the op presented then.
- `ras_full`/`ras_empty` change in the same cycle as `ras_count`.

## Structure

- Shared package `pc_pkg`: op encodings (OP_NEXT=0, OP_JUMP=1, OP_BRANCH_REL=2, OP_CALL=3, OP_RET=4) as localparams, reused by decode.
- Sub-module `return_stack`: parametrised LIFO (WIDTH, DEPTH) with push/pop/top/count/full/empty and async active-low reset; the top level holds `pc`, next-PC mux and sticky flags.

## Test plan

Default parameters throughout.
- Reset, then `latch`=1, op=NEXT for 3 cycles → `pc` 0, 8, 16, 24; `latch`=0 for 2 cycles → `pc` stays 24.
- op=JUMP `target`=0x100 → `pc`=0x100; op=BRANCH_REL `target`=0xFFFFFFF0 → `pc`=0xF0; op=BRANCH_REL `target`=0x20 → `pc`=0x110.
- At `pc`=0x40: CALL 0x200 → `pc`=0x200, `ras_count`=1; NEXT → 0x208; CALL 0x300 → `ras_count`=2; RET → `pc`=0x210; RET → `pc`=0x48, `ras_empty`=1.
- 8 CALLs → `ras_full`=1; 9th CALL to 0x900 → `pc`=0x900, `ras_count`=8, `ras_overflow`=1; 8 RETs return in reverse push order; further RET → `pc` advances by 8, `ras_underflow`=1; both flags remain 1 afterwards.
- `pc`=0xFFFFFFF8, NEXT → `pc`=0; op=6 → behaves as NEXT.
- Assert `rst`=0 mid-cycle with `ras_count`=3 and flags set → `pc`=0, `ras_count`=0, flags 0 before the next clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared operation encodings for the fetch-address generator; decode imports
// the same constants so both sides agree on the op field.
package pc_pkg;

   localparam int OP_WIDTH = 3;

   localparam logic [OP_WIDTH-1:0] OP_NEXT       = 3'd0;
   localparam logic [OP_WIDTH-1:0] OP_JUMP       = 3'd1;
   localparam logic [OP_WIDTH-1:0] OP_BRANCH_REL = 3'd2;
   localparam logic [OP_WIDTH-1:0] OP_CALL       = 3'd3;
   localparam logic [OP_WIDTH-1:0] OP_RET        = 3'd4;

endpackage

// File: rtl/program_counter_ras_return_stack.sv
// Parametrised LIFO holding return addresses. Pushes while full and pops while
// empty are ignored here; the caller decides how to flag them.
module return_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic [CW-1:0]    top_pos;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    top_idx;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign top_pos = count_q - CW'(1);
   assign wr_idx  = IW'(count_q);
   assign top_idx = IW'(top_pos);
   assign count   = count_q;

   // Entry at count-1 is the most recent unpopped push.
   assign top = mem_q[top_idx];

   always_comb begin
      count_d = count_q;
      if (do_push) begin
         count_d = count_q + CW'(1);
      end else if (do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_idx] <= push_data;
      end
   end

endmodule

// File: rtl/program_counter_ras.sv
// Fetch-address generator: sequential advance, absolute jump, relative branch
// and call/return through a hardware return-address stack.
module program_counter_ras
   import pc_pkg::*;
#(
   parameter int                     PC_WIDTH     = 32,
   parameter int                     INSTR_BYTES  = 8,
   parameter int                     RAS_DEPTH    = 8,
   parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
   localparam int                    CW = $clog2(RAS_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                latch,
   input  logic [OP_WIDTH-1:0] op,
   input  logic [PC_WIDTH-1:0] target,
   output logic [PC_WIDTH-1:0] pc,
   output logic [CW-1:0]       ras_count,
   output logic                ras_full,
   output logic                ras_empty,
   output logic                ras_overflow,
   output logic                ras_underflow
);

   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_d;
   logic [PC_WIDTH-1:0] seq_pc;
   logic [PC_WIDTH-1:0] ras_top;
   logic                overflow_q;
   logic                overflow_d;
   logic                underflow_q;
   logic                underflow_d;
   logic                push;
   logic                pop;

   assign seq_pc = pc_q + PC_WIDTH'(INSTR_BYTES);

   return_stack #(
      .WIDTH (PC_WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   always_comb begin
      pc_d        = pc_q;
      push        = 1'b0;
      pop         = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (latch) begin
         case (op)
            OP_JUMP:       pc_d = target;
            OP_BRANCH_REL: pc_d = pc_q + target;
            OP_CALL: begin
               // The jump is taken even when the return address cannot be kept.
               pc_d = target;
               push = 1'b1;
               if (ras_full) overflow_d = 1'b1;
            end
            OP_RET: begin
               if (ras_empty) begin
                  pc_d        = seq_pc;
                  underflow_d = 1'b1;
               end else begin
                  pc_d = ras_top;
                  pop  = 1'b1;
               end
            end
            default:       pc_d = seq_pc;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_VECTOR;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign pc            = pc_q;
   assign ras_overflow  = overflow_q;
   assign ras_underflow = underflow_q;

endmodule
